// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core-side memory port shared by fetch and load/store
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding IF/LS arbiter for the core memory port
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int INST_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req_i,
    input  logic [ADDR_W-1:0]    if_addr_i,
    input  logic                 if_flush_i,
    output logic                 if_gnt_o,
    output logic                 if_rvalid_o,
    output logic [INST_W-1:0]    if_rdata_o,
    input  logic                 ls_req_i,
    input  logic                 ls_we_i,
    input  logic [ADDR_W-1:0]    ls_addr_i,
    input  logic [DATA_W-1:0]    ls_wdata_i,
    input  logic [DATA_W/8-1:0]  ls_wstrb_i,
    output logic                 ls_gnt_o,
    output logic                 ls_rvalid_o,
    output logic [DATA_W-1:0]    ls_rdata_o,
    mem_port_arbiter_if.master   mem,
    output logic                 hold_flag_o
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_ls;
    logic              drop;
    logic [CNT_W-1:0]  starve_cnt;
    logic              grant_if;
    logic              grant_ls;
    logic              if_ok;
    logic              resp;
    logic [INST_W-1:0] if_lane;

    // A fetch raised in the same cycle as a jump is stale and must not win
    assign if_ok = if_req_i & ~if_flush_i;

    // Arbitration and next state; grants only leave IDLE so one transaction is outstanding
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (ls_req_i && if_ok && (starve_cnt < STARVE_LIM)) begin
                        grant_ls = 1'b1;
                    end else if (if_ok) begin
                        grant_if = 1'b1;
                    end else if (ls_req_i) begin
                        grant_ls = 1'b1;
                    end
                end
                if (grant_if || grant_ls) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem.gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem.rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture owner and request payload on the grant so the bus sees stable values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_ls  <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            mem.wstrb <= '0;
        end else if (grant_ls) begin
            owner_ls  <= 1'b1;
            mem.we    <= ls_we_i;
            mem.addr  <= ls_addr_i;
            mem.wdata <= ls_wdata_i;
            mem.wstrb <= ls_wstrb_i;
        end else if (grant_if) begin
            owner_ls  <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= if_addr_i;
            mem.wdata <= '0;
            mem.wstrb <= '0;
        end
    end

    // A jump during an in-flight fetch marks its response for discard until the bus frees up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (state == IDLE || (state == WAIT && mem.rvalid)) begin
            drop <= 1'b0;
        end else if (if_flush_i && !owner_ls) begin
            drop <= 1'b1;
        end
    end

    // Count LS wins while a fetch is waiting; once saturated the fetch takes the next slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req_i || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_ls && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign resp    = (state == WAIT) & mem.rvalid;
    assign if_lane = mem.addr[2] ? mem.rdata[2*INST_W-1:INST_W] : mem.rdata[INST_W-1:0];

    assign mem.req     = (state == REQ);
    assign if_gnt_o    = grant_if;
    assign ls_gnt_o    = grant_ls;
    assign if_rvalid_o = resp & ~owner_ls & ~drop & ~if_flush_i;
    assign if_rdata_o  = if_rvalid_o ? if_lane : '0;
    assign ls_rvalid_o = resp & owner_ls;
    assign ls_rdata_o  = ls_rvalid_o ? mem.rdata : '0;
    assign hold_flag_o = ~rst & ((ls_req_i & ~grant_ls) | (owner_ls & (state != IDLE)));
endmodule
